symbol_freq_ranker: RTL and testbench
=====================================

# symbol_freq_ranker

Upstream stage of the canonical Huffman encoder. Captures a 20-symbol block and counts the occurrences of each distinct 8-bit symbol, up to 5 distinct symbols. It then emits the distinct symbols one per cycle in ascending-frequency order. Its outputs drive the code-table stage directly: `buffer_data`, `syml_out`, `syml_enb` and `done` map onto that stage's Buffer_Data, Bitmap_Syml_out, Bitmap_enb and Bitmap_done.

## Interface
Parameters:
- NSYM, 20, symbols per block
- SYMW, 8, symbol width in bits
- MAXD, 5, maximum number of distinct symbols tracked

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse; starts a block
- data_in  in  NSYM*SYMW (160)  block input; symbol i = data_in[8i+7:8i]
- buffer_data  out  160  block latched on the accepted start
- syml_out  out  SYMW  symbol being emitted
- syml_freq  out  5  occurrence count of syml_out (1..20)
- syml_enb  out  1  syml_out/syml_freq valid this cycle
- done  out  1  level; ranking available, emission started
- busy  out  1  high from the accepted start until the DONE state is reached
- overflow  out  1  sticky per block; more than MAXD distinct symbols seen

## Operation
- Reset value of every output is 0. All state is cleared and the FSM returns to IDLE.
- States: IDLE, COUNT, EMIT, DONE.
- IDLE or DONE:
  - `start=1` latches data_in into buffer_data.
  - Clears the table, overflow, done and the symbol index.
  - Sets busy and moves to COUNT.
- A `start` seen in COUNT or EMIT is ignored and has no effect.
- COUNT processes symbol index k = 0..19, one per cycle, from buffer_data. Per symbol:
  - If it matches a valid table slot, that slot's count increments.
  - Otherwise, if a slot is free, the lowest free slot is allocated with count 1. Slots therefore fill in order of first appearance.
  - Otherwise overflow is set and the symbol is dropped.
- After k=19, the FSM moves to EMIT.
- EMIT, each cycle:
  - Selects the unemitted valid slot with the minimum count. Ties go to the lowest slot index, i.e. the symbol that appeared earliest.
  - Drives syml_out/syml_freq from that slot, pulses syml_enb=1 and marks the slot emitted.
  - done goes high on the first EMIT cycle and stays high.
- After D emissions (D = number of valid slots, 1..5), the FSM moves to DONE.
- DONE: syml_enb=0, busy=0, done=1. buffer_data is held stable until the next accepted start.
- Counts are 5-bit and saturate-free, since the maximum is 20. Comparisons are unsigned.

## Timing
- Accepted start sampled at edge E0: buffer_data and busy are valid after E0, and done is cleared after E0.
- COUNT occupies edges E1..E20.
- Registered syml_enb is high after edges E21..E20+D, exactly D consecutive cycles with no gaps.
- done rises after E21, together with the first syml_enb.
- busy falls after E20+D.
- Total latency from start to last emission: 20+D cycles.
- A start sampled at the same edge as the last emission is ignored (state is still EMIT).
- An asynchronous reset at any point, including mid-COUNT or mid-EMIT:
  - All outputs go to 0 immediately.
  - No partial emission resumes after reset is released.

## Test plan
- **Canonical block:** counts D(0x44)=2, C(0x43)=3, A(0x41)=4, E(0x45)=5, B(0x42)=6, interleaved. Start at E0 -> syml_enb high for 5 cycles after E21..E25 with syml_out 0x44,0x43,0x41,0x45,0x42 and freq 2,3,4,5,6. done rises after E21. busy falls after E25. overflow=0.
- **Ties:** first-appearance order 0x10,0x20,0x30,0x40 with counts 5,5,5,5 -> emit order 0x10,0x20,0x30,0x40, all with freq 5.
- **Single symbol:** all 20 symbols = 0x41 -> one emission, 0x41 with freq 20. done after E21. busy falls after E21.
- **Overflow:** symbols 0x01..0x06 with 0x06 appearing once, last -> overflow=1. Only 0x01..0x05 are emitted. The 0x06 occurrence is not counted.
- **Ignored start:** extra start pulses at E5 and E15 -> results identical to the canonical block, and buffer_data unchanged.
- **Reset mid-EMIT:** reset asserted after E23 -> all outputs 0 at once. After release, the block stays in IDLE with no emissions. A fresh start then reproduces the canonical results.

Source files
------------

// File: rtl/symbol_freq_ranker.sv
// symbol_freq_ranker: captures a block of NSYM symbols, counts the occurrences
// of up to MAXD distinct symbols, then emits the distinct symbols one per cycle
// in ascending-frequency order. Ties go to the symbol that appeared first.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   start           one-cycle pulse, accepted only in IDLE or DONE
//   data_in         block input, symbol i = data_in[SYMW*i +: SYMW]
//   buffer_data     block latched on the accepted start
//   syml_out        symbol being emitted
//   syml_freq       occurrence count of syml_out
//   syml_enb        syml_out/syml_freq valid this cycle
//   done            level, high from the first emission until the next start
//   busy            high from the accepted start until DONE is reached
//   overflow        sticky per block, more than MAXD distinct symbols seen
module symbol_freq_ranker #(
  parameter int unsigned NSYM = 20,
  parameter int unsigned SYMW = 8,
  parameter int unsigned MAXD = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NSYM*SYMW-1:0] data_in,
  output logic [NSYM*SYMW-1:0] buffer_data,
  output logic [SYMW-1:0]      syml_out,
  output logic [4:0]           syml_freq,
  output logic                 syml_enb,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow
);

  localparam int unsigned BUFW = NSYM * SYMW;
  localparam int unsigned CNTW = 5;
  localparam int unsigned KW   = $clog2(NSYM);
  localparam int unsigned DW   = $clog2(MAXD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [BUFW-1:0]           buffer_data_q, buffer_data_d;
  logic [KW-1:0]             k_q, k_d;
  logic [MAXD-1:0][SYMW-1:0] sym_q, sym_d;
  logic [MAXD-1:0][CNTW-1:0] cnt_q, cnt_d;
  logic [MAXD-1:0]           vld_q, vld_d;
  logic [MAXD-1:0]           emitted_q, emitted_d;
  logic                      overflow_q, overflow_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic [SYMW-1:0]           syml_out_q, syml_out_d;
  logic [CNTW-1:0]           syml_freq_q, syml_freq_d;
  logic                      syml_enb_q, syml_enb_d;

  // Scratch values for the count and selection logic
  logic [SYMW-1:0]           cur_sym;
  logic                      hit;
  logic                      free_found;
  logic                      sel_found;
  logic [CNTW-1:0]           sel_cnt;
  logic [SYMW-1:0]           sel_sym;
  logic [MAXD-1:0]           sel_oh;
  logic [DW-1:0]             cand_cnt;

  // Next-state and datapath
  always_comb begin
    state_d       = state_q;
    buffer_data_d = buffer_data_q;
    k_d           = k_q;
    sym_d         = sym_q;
    cnt_d         = cnt_q;
    vld_d         = vld_q;
    emitted_d     = emitted_q;
    overflow_d    = overflow_q;
    done_d        = done_q;
    busy_d        = busy_q;
    syml_out_d    = syml_out_q;
    syml_freq_d   = syml_freq_q;
    syml_enb_d    = 1'b0;
    cur_sym       = '0;
    hit           = 1'b0;
    free_found    = 1'b0;
    sel_found     = 1'b0;
    sel_cnt       = '0;
    sel_sym       = '0;
    sel_oh        = '0;
    cand_cnt      = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          buffer_data_d = data_in;
          sym_d         = '0;
          cnt_d         = '0;
          vld_d         = '0;
          emitted_d     = '0;
          overflow_d    = 1'b0;
          done_d        = 1'b0;
          k_d           = '0;
          busy_d        = 1'b1;
          state_d       = COUNT;
        end
      end

      COUNT: begin
        for (int unsigned i = 0; i < NSYM; i++) begin
          if (k_q == KW'(i)) cur_sym = buffer_data_q[i*SYMW +: SYMW];
        end
        for (int unsigned i = 0; i < MAXD; i++) begin
          if (vld_q[i] && (sym_q[i] == cur_sym)) begin
            hit      = 1'b1;
            cnt_d[i] = cnt_q[i] + CNTW'(1);
          end
        end
        // Slots fill strictly in order, so the first free slot is the lowest
        if (!hit) begin
          for (int unsigned i = 0; i < MAXD; i++) begin
            if (!vld_q[i] && !free_found) begin
              free_found = 1'b1;
              vld_d[i]   = 1'b1;
              sym_d[i]   = cur_sym;
              cnt_d[i]   = CNTW'(1);
            end
          end
          if (!free_found) overflow_d = 1'b1;
        end
        k_d = k_q + KW'(1);
        if (k_q == KW'(NSYM - 1)) state_d = EMIT;
      end

      EMIT: begin
        // Strict less-than keeps the lowest slot index on equal counts
        for (int unsigned i = 0; i < MAXD; i++) begin
          if (vld_q[i] && !emitted_q[i]) begin
            cand_cnt = cand_cnt + DW'(1);
            if (!sel_found || (cnt_q[i] < sel_cnt)) begin
              sel_found = 1'b1;
              sel_cnt   = cnt_q[i];
              sel_sym   = sym_q[i];
              sel_oh    = '0;
              sel_oh[i] = 1'b1;
            end
          end
        end
        if (sel_found) begin
          syml_out_d  = sel_sym;
          syml_freq_d = sel_cnt;
          syml_enb_d  = 1'b1;
          emitted_d   = emitted_q | sel_oh;
          done_d      = 1'b1;
        end
        // Leave EMIT on the cycle that emits the last remaining symbol
        if (cand_cnt <= DW'(1)) begin
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      buffer_data_q <= '0;
      k_q           <= '0;
      sym_q         <= '0;
      cnt_q         <= '0;
      vld_q         <= '0;
      emitted_q     <= '0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      syml_out_q    <= '0;
      syml_freq_q   <= '0;
      syml_enb_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      buffer_data_q <= buffer_data_d;
      k_q           <= k_d;
      sym_q         <= sym_d;
      cnt_q         <= cnt_d;
      vld_q         <= vld_d;
      emitted_q     <= emitted_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      syml_out_q    <= syml_out_d;
      syml_freq_q   <= syml_freq_d;
      syml_enb_q    <= syml_enb_d;
    end
  end

  assign buffer_data = buffer_data_q;
  assign syml_out    = syml_out_q;
  assign syml_freq   = syml_freq_q;
  assign syml_enb    = syml_enb_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_symbol_freq_ranker.sv
// tb_symbol_freq_ranker: directed blocks with hand-computed emission lists;
// expected emissions are queued by the stimulus and checked by a monitor.
module tb_symbol_freq_ranker;

  logic         clk;
  logic         reset;
  logic         start;
  logic [159:0] data_in;
  logic [159:0] buffer_data;
  logic [7:0]   syml_out;
  logic [4:0]   syml_freq;
  logic         syml_enb;
  logic         done;
  logic         busy;
  logic         overflow;

  typedef struct {
    logic [7:0] s;
    logic [4:0] f;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         e0     = 0;
  logic [7:0] es [5];
  logic [4:0] ef [5];

  symbol_freq_ranker dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data_in     (data_in),
    .buffer_data (buffer_data),
    .syml_out    (syml_out),
    .syml_freq   (syml_freq),
    .syml_enb    (syml_enb),
    .done        (done),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every emission must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset && syml_enb) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL emit_unexpected: got sym %0h freq %0d with nothing expected (cycle %0d)",
                 syml_out, syml_freq, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (syml_out !== e.s || syml_freq !== e.f || cyc != e.cyc) begin
          errors++;
          $display("FAIL emit: got sym %0h freq %0d cycle %0d expected sym %0h freq %0d cycle %0d",
                   syml_out, syml_freq, cyc, e.s, e.f, e.cyc);
        end
      end
    end
  end

  function automatic logic [159:0] from_str(input string s);
    logic [159:0] v;
    v = '0;
    for (int i = 0; i < 20; i++) v[i*8 +: 8] = s[i];
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_buf"},  buffer_data, 160'd0);
    chk({tag, "_sym"},  160'(syml_out), 160'd0);
    chk({tag, "_freq"}, 160'(syml_freq), 160'd0);
    chk({tag, "_enb"},  160'(syml_enb), 160'd0);
    chk({tag, "_done"}, 160'(done), 160'd0);
    chk({tag, "_busy"}, 160'(busy), 160'd0);
    chk({tag, "_ovf"},  160'(overflow), 160'd0);
  endtask

  // Runs one block; stop_r > 0 ends the run early after edge E0+stop_r
  task automatic run_block(input string tag, input logic [159:0] dat, input int d,
                           input bit xs, input bit ovf, input int stop_r);
    int last_r;
    int npush;
    @(negedge clk);
    data_in = dat;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = ~dat;
    e0      = cyc;
    npush   = (stop_r > 0 && stop_r - 20 < d) ? stop_r - 20 : d;
    for (int j = 0; j < npush; j++) sb.push_back('{s: es[j], f: ef[j], cyc: e0 + 21 + j});
    chk({tag, "_e0_busy"}, 160'(busy), 160'd1);
    chk({tag, "_e0_done"}, 160'(done), 160'd0);
    chk({tag, "_e0_ovf"},  160'(overflow), 160'd0);
    chk({tag, "_e0_buf"},  buffer_data, dat);
    last_r = (stop_r > 0) ? stop_r : 20 + d + 2;
    for (int r = 1; r <= last_r; r++) begin
      @(negedge clk);
      chk({tag, "_buf"},  buffer_data, dat);
      chk({tag, "_busy"}, 160'(busy), 160'(r < 20 + d));
      chk({tag, "_done"}, 160'(done), 160'(r >= 21));
      start = (xs && (r == 4 || r == 14)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    if (stop_r == 0) begin
      chk({tag, "_drained"}, 160'(sb.size()), 160'd0);
      chk({tag, "_ovf"}, 160'(overflow), 160'(ovf));
    end
  endtask

  logic [159:0] canon;
  logic [159:0] blk;

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    canon   = from_str("ABCDEBACEBDACEBAEBEB");
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // Canonical: D2 C3 A4 E5 B6
    es = '{8'h44, 8'h43, 8'h41, 8'h45, 8'h42};
    ef = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    run_block("canon", canon, 5, 1'b0, 1'b0, 0);

    // Ties: four symbols with 5 each, first-appearance order wins
    for (int i = 0; i < 20; i++) blk[i*8 +: 8] = 8'(((i % 4) + 1) * 16);
    es = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00};
    ef = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd0};
    run_block("ties", blk, 4, 1'b0, 1'b0, 0);

    // Single symbol
    for (int i = 0; i < 20; i++) blk[i*8 +: 8] = 8'h41;
    es = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00};
    ef = '{5'd20, 5'd0, 5'd0, 5'd0, 5'd0};
    run_block("single", blk, 1, 1'b0, 1'b0, 0);

    // Overflow: 01..04 x4, 05 x3, 06 once at the end and dropped
    for (int i = 0; i < 20; i++) blk[i*8 +: 8] = (i < 19) ? 8'((i % 5) + 1) : 8'h06;
    es = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
    ef = '{5'd3, 5'd4, 5'd4, 5'd4, 5'd4};
    run_block("ovf", blk, 5, 1'b0, 1'b1, 0);

    // Ignored starts during COUNT
    es = '{8'h44, 8'h43, 8'h41, 8'h45, 8'h42};
    ef = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    run_block("xstart", canon, 5, 1'b1, 1'b0, 0);

    // Reset mid-EMIT after E23
    run_block("rst", canon, 5, 1'b0, 1'b0, 23);
    #2 reset = 1'b0;
    #1 chk_all_zero("rst_now");
    chk("rst_sb", 160'(sb.size()), 160'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      if (r % 10 == 0) begin
        chk("post_rst_enb",  160'(syml_enb), 160'd0);
        chk("post_rst_busy", 160'(busy), 160'd0);
        chk("post_rst_done", 160'(done), 160'd0);
      end
    end
    run_block("after_rst", canon, 5, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
